// File: rtl/conv_mc_engine.sv
// conv_mc_engine: multi-channel 3x3 "same" convolution engine.
// Buffers a full CH x IMG_H x IMG_W frame plus one 3x3 kernel per channel,
// then emits one saturated result per cycle in raster order as a gap-free burst.
// Optional ReLU on the output is compiled in only when CONV_MC_RELU_EN is defined.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous reset, active HIGH (name kept for codebase compatibility)
//   in_valid  - frame input strobe, IMG_W*IMG_H consecutive cycles per frame
//   img       - one pixel per channel, channel c at [c*DW +: DW]
//   kernel    - one coefficient per channel, used on the first 9 input cycles
//   opt       - bit0 replicate padding, bit1 ReLU request; latched on first input cycle
//   busy      - frame in progress
//   out_valid - result strobe
//   out       - signed saturated result, zero when out_valid is low
module conv_mc_engine #(
  parameter int unsigned IMG_W = 5,
  parameter int unsigned IMG_H = 5,
  parameter int unsigned CH    = 2,
  parameter int unsigned DW    = 8,
  parameter int unsigned KW    = 8,
  parameter int unsigned OW    = 21
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [CH*DW-1:0]     img,
  input  logic [CH*KW-1:0]     kernel,
  input  logic [1:0]           opt,
  output logic                 busy,
  output logic                 out_valid,
  output logic signed [OW-1:0] out
);

  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned AD = $clog2(N);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned NT = 9 * CH;
  localparam int unsigned PW = DW + KW;
  localparam int unsigned AW = DW + KW + $clog2(NT);
  localparam int unsigned XW = (AW > OW) ? AW : OW;

  localparam logic signed [XW-1:0] SAT_MAX = XW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [XW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic          load_en, load_last, frame_start;
  logic [AD-1:0] load_cnt;
  logic [AD-1:0] out_cnt;
  logic          rep_q;

  logic          issue_on;
  logic [RW-1:0] issue_row;
  logic [CW-1:0] issue_col;

  logic                 p1_valid, p2_valid;
  logic [NT*PW-1:0]     prod_q;
  logic signed [AW-1:0] acc_c;
  logic signed [AW-1:0] p2_sum;
  logic signed [XW-1:0] sum_x;
  logic signed [OW-1:0] res_c;

  logic [CH*DW-1:0] pix_mem [N];
  logic [NT*KW-1:0] coef_q;

`ifdef CONV_MC_RELU_EN
  logic relu_q;
`else
  logic unused_relu_opt;
  assign unused_relu_opt = opt[1];
`endif

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (in_valid) state_nx = S_LOAD;
      S_LOAD: if (in_valid && (load_cnt == AD'(N - 1))) state_nx = S_CALC;
      S_CALC: if (p2_valid) state_nx = S_OUT;
      S_OUT:  if (out_valid && (out_cnt == AD'(N - 1))) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM control outputs; input is accepted only in IDLE and LOAD
  always_comb begin
    load_en     = 1'b0;
    load_last   = 1'b0;
    frame_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        load_en     = in_valid;
        frame_start = in_valid;
      end
      S_LOAD: begin
        load_en   = in_valid;
        load_last = in_valid && (load_cnt == AD'(N - 1));
      end
      default: ;
    endcase
  end

  // Pixel of channel c at (r,q); out-of-range reads clamp (replicate) or return 0
  function automatic logic signed [DW-1:0] fetch(input int c, input int r, input int q,
                                                 input logic rep);
    int               rr;
    int               qq;
    logic             hit;
    logic [CH*DW-1:0] word;
    hit = (r >= 0) && (r < int'(IMG_H)) && (q >= 0) && (q < int'(IMG_W));
    rr  = r;
    qq  = q;
    if (rr < 0) rr = 0;
    if (rr > int'(IMG_H) - 1) rr = int'(IMG_H) - 1;
    if (qq < 0) qq = 0;
    if (qq > int'(IMG_W) - 1) qq = int'(IMG_W) - 1;
    word = pix_mem[AD'(rr * int'(IMG_W) + qq)];
    if (!rep && !hit) word = '0;
    return $signed(word[c*DW +: DW]);
  endfunction

  // Frame/kernel storage and product stage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (load_en) pix_mem[load_cnt] <= img;
    if (load_en && (load_cnt < AD'(9)))
      coef_q[int'(load_cnt)*int'(CH*KW) +: CH*KW] <= kernel;
    if (issue_on) begin
      for (int k = 0; k < 9; k++) begin
        for (int c = 0; c < int'(CH); c++) begin
          prod_q[(k*int'(CH) + c)*int'(PW) +: PW] <=
            PW'($signed(coef_q[(k*int'(CH) + c)*int'(KW) +: KW])) *
            PW'(fetch(c, int'(issue_row) + k/3 - 1, int'(issue_col) + k%3 - 1, rep_q));
        end
      end
    end
    if (p1_valid) p2_sum <= acc_c;
  end

  // Full-precision sum of all 9*CH products
  always_comb begin
    acc_c = '0;
    for (int e = 0; e < int'(NT); e++)
      acc_c = acc_c + AW'($signed(prod_q[e*int'(PW) +: PW]));
  end

  // Saturate to OW, then optional ReLU
  always_comb begin
    sum_x = XW'(p2_sum);
    if (sum_x > SAT_MAX)      res_c = OW'(SAT_MAX);
    else if (sum_x < SAT_MIN) res_c = OW'(SAT_MIN);
    else                      res_c = OW'(sum_x);
`ifdef CONV_MC_RELU_EN
    if (relu_q && res_c[OW-1]) res_c = '0;
`endif
  end

  // Control counters, pipeline valids and registered outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      load_cnt  <= '0;
      out_cnt   <= '0;
      rep_q     <= 1'b0;
      issue_on  <= 1'b0;
      issue_row <= '0;
      issue_col <= '0;
      p1_valid  <= 1'b0;
      p2_valid  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
`ifdef CONV_MC_RELU_EN
      relu_q    <= 1'b0;
`endif
    end else begin
      busy <= (state_nx != S_IDLE);

      if (load_en) load_cnt <= load_last ? '0 : load_cnt + AD'(1);

      if (frame_start) begin
        rep_q <= opt[0];
`ifdef CONV_MC_RELU_EN
        relu_q <= opt[1];
`endif
      end

      // Raster walk over output positions, starting right after the last pixel lands
      if (load_last) begin
        issue_on  <= 1'b1;
        issue_row <= '0;
        issue_col <= '0;
      end else if (issue_on) begin
        if (issue_col == CW'(IMG_W - 1)) begin
          issue_col <= '0;
          if (issue_row == RW'(IMG_H - 1)) begin
            issue_row <= '0;
            issue_on  <= 1'b0;
          end else begin
            issue_row <= issue_row + RW'(1);
          end
        end else begin
          issue_col <= issue_col + CW'(1);
        end
      end

      p1_valid  <= issue_on;
      p2_valid  <= p1_valid;
      out_valid <= p2_valid;
      out       <= p2_valid ? res_c : '0;

      if (out_valid) out_cnt <= (out_cnt == AD'(N - 1)) ? '0 : out_cnt + AD'(1);
    end
  end

endmodule

// File: tb/tb_conv_mc_engine.sv
// Testbench for conv_mc_engine: directed and random frames against a
// behavioural convolution model; a second instance with OW=8 covers saturation.
module tb_conv_mc_engine;

  localparam int W   = 5;
  localparam int H   = 5;
  localparam int C   = 2;
  localparam int DW  = 8;
  localparam int KW  = 8;
  localparam int OW  = 21;
  localparam int OW8 = 8;
  localparam int N   = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic                  in_valid;
  logic [C*DW-1:0]       img;
  logic [C*KW-1:0]       kernel;
  logic [1:0]            opt;
  logic                  busy, out_valid;
  logic signed [OW-1:0]  out_w;
  logic                  busy8, out_valid8;
  logic signed [OW8-1:0] out8;

  conv_mc_engine #(.IMG_W(W), .IMG_H(H), .CH(C), .DW(DW), .KW(KW), .OW(OW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .img(img), .kernel(kernel),
    .opt(opt), .busy(busy), .out_valid(out_valid), .out(out_w)
  );

  conv_mc_engine #(.IMG_W(W), .IMG_H(H), .CH(C), .DW(DW), .KW(KW), .OW(OW8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .img(img), .kernel(kernel),
    .opt(opt), .busy(busy8), .out_valid(out_valid8), .out(out8)
  );

  int         px [C][H][W];
  int         kr [C][9];
  logic [1:0] fopt;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_pix(int c, int r, int q);
    if (fopt[0]) begin
      r = (r < 0) ? 0 : (r > H - 1) ? H - 1 : r;
      q = (q < 0) ? 0 : (q > W - 1) ? W - 1 : q;
    end else if (r < 0 || r >= H || q < 0 || q >= W) begin
      return 0;
    end
    return longint'(px[c][r][q]);
  endfunction

  function automatic longint ref_out(int r, int q, int ow);
    longint s = 0;
    longint mx = (longint'(1) <<< (ow - 1)) - 1;
    for (int c = 0; c < C; c++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          s += longint'(kr[c][i*3+j]) * ref_pix(c, r + i - 1, q + j - 1);
    if (s > mx) s = mx;
    if (s < -mx - 1) s = -mx - 1;
`ifdef CONV_MC_RELU_EN
    if (fopt[1] && s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic set_const(input int pv0, input int pv1, input int kv0, input int kv1,
                           input logic [1:0] o);
    for (int r = 0; r < H; r++)
      for (int q = 0; q < W; q++) begin
        px[0][r][q] = pv0;
        px[1][r][q] = pv1;
      end
    for (int k = 0; k < 9; k++) begin
      kr[0][k] = kv0;
      kr[1][k] = kv1;
    end
    fopt = o;
  endtask

  function automatic int rnd8();
    logic [7:0] b = 8'($urandom);
    return int'($signed(b));
  endfunction

  // Called right after a negedge. abort_k >= 0 pulses reset during that output.
  task automatic run_frame(input int abort_k, input bit junk);
    longint e21 [N];
    longint e8  [N];
    for (int t = 0; t < N; t++) begin
      e21[t] = ref_out(t / W, t % W, OW);
      e8[t]  = ref_out(t / W, t % W, OW8);
    end
    for (int t = 0; t < N; t++) begin
      for (int c = 0; c < C; c++) begin
        img[c*DW +: DW]    = DW'(px[c][t / W][t % W]);
        kernel[c*KW +: KW] = (t < 9) ? KW'(kr[c][t]) : KW'($urandom);
      end
      opt      = (t == 0) ? fopt : 2'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    img      = C*DW'($urandom);
    chk("busy_load", longint'(busy), 1);
    chk("busy8_load", longint'(busy8), 1);
    chk("lat_t0", longint'(out_valid), 0);
    @(negedge clk);
    in_valid = junk;
    chk("lat_t1", longint'(out_valid), 0);
    @(negedge clk);
    chk("lat_t2", longint'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("ov", longint'(out_valid), 1);
      chk("out", longint'(out_w), e21[k]);
      chk("ov8", longint'(out_valid8), 1);
      chk("out8", longint'(out8), e8[k]);
      if (k == abort_k) begin
        #2 rst_n = 1'b1;
        #1;
        chk("rst_ov", longint'(out_valid), 0);
        chk("rst_out", longint'(out_w), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_ov8", longint'(out_valid8), 0);
        @(negedge clk);
        rst_n = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("end_ov", longint'(out_valid), 0);
    chk("end_out", longint'(out_w), 0);
    chk("end_busy", longint'(busy), 0);
    chk("end_ov8", longint'(out_valid8), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    img      = '0;
    kernel   = '0;
    opt      = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_ov", longint'(out_valid), 0);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_out", longint'(out_w), 0);
    rst_n = 1'b0;
    @(negedge clk);

    // All ones, both paddings
    set_const(1, 1, 1, 1, 2'b00);
    run_frame(-1, 1'b0);
    set_const(1, 1, 1, 1, 2'b01);
    run_frame(-1, 1'b1);

    // Identity kernel on ch0 over a ramp, both paddings
    for (int p = 0; p < 2; p++) begin
      set_const(0, 0, 0, 0, 2'(p));
      kr[0][4] = 1;
      for (int r = 0; r < H; r++)
        for (int q = 0; q < W; q++) begin
          px[0][r][q] = 5 * r + q;
          px[1][r][q] = rnd8();
        end
      run_frame(-1, 1'b0);
    end

    // Negative sums, without and with ReLU request
    set_const(-1, 3, 1, 0, 2'b00);
    run_frame(-1, 1'b0);
    set_const(-1, 3, 1, 0, 2'b10);
    run_frame(-1, 1'b0);

    // Saturation extremes
    set_const(127, 127, 127, 127, 2'b01);
    run_frame(-1, 1'b0);
    set_const(-128, -128, 127, 127, 2'b01);
    run_frame(-1, 1'b0);

    // Random frames, back to back
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < C; c++) begin
        for (int r = 0; r < H; r++)
          for (int q = 0; q < W; q++) px[c][r][q] = rnd8();
        for (int k = 0; k < 9; k++) kr[c][k] = rnd8();
      end
      fopt = 2'($urandom);
      run_frame(-1, 1'($urandom));
    end

    // Reset mid-burst, then a clean frame
    run_frame(9, 1'b0);
    set_const(2, -3, 1, 1, 2'b00);
    kr[1][0] = -5;
    kr[0][8] = 7;
    run_frame(-1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_mc_engine.md
Name: conv_mc_engine

Overview:
- Parametrised successor to the team's fixed-size CNN convolution block.
- Streams a CH-channel IMG_H x IMG_W signed-integer image and one 3x3 kernel per channel.
- Computes a "same"-size 2D convolution summed across channels, with selectable zero or replicate padding and optional ReLU.
- Emits the result raster-order as a contiguous burst. Sits ahead of the FC/activation stage in the CNN datapath.

Parameters:
- IMG_W, 5, image width in pixels (>=3)
- IMG_H, 5, image height in pixels (>=3; IMG_W*IMG_H >= 9)
- CH, 2, input channel count (1..4)
- DW, 8, signed pixel width
- KW, 8, signed kernel coefficient width
- OW, 21, signed output width; results outside range saturate

Ports:
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, asynchronous reset. Active-HIGH despite the suffix (kept for codebase port naming): asserted = 1.
- in_valid, in, 1, frame input strobe; high for exactly IMG_W*IMG_H consecutive cycles per frame
- img, in, CH*DW, one pixel per channel at the same (row,col); channel c at bits [c*DW +: DW]
- kernel, in, CH*KW, one coefficient per channel; valid only in the first 9 in_valid cycles
- opt, in, 2, bit0: 0=zero pad, 1=replicate pad; bit1: ReLU request (see Optional Feature); sampled on the first in_valid cycle only
- busy, out, 1, high from first in_valid cycle until the cycle after the last out_valid
- out_valid, out, 1, result strobe
- out, out, OW, signed result; 0 whenever out_valid=0

Behaviour:
- Reset (async, any state): busy=0, out_valid=0, out=0, FSM->IDLE. Partial frame, kernels and pipeline are discarded.
- FSM: IDLE -> LOAD on in_valid=1; LOAD -> CALC after the IMG_W*IMG_H-th input; CALC -> OUT when the first result leaves the pipeline; OUT -> IDLE after IMG_W*IMG_H results.
- Input order: pixels are raster order, row 0 col 0 first. Kernel cells are row-major k(0,0)..k(2,2) on input cycles 0..8. Kernel is ignored on later cycles.
- Storage: full frame buffer CH*IMG_H*IMG_W*DW bits plus 9*CH coefficients.
- Compute: one output pixel per cycle, 9*CH multipliers, two register stages (products, then sum/clip).
- Latency: with the last in_valid sampled at edge T, the first out_valid=1 is at edge T+3. out_valid then stays high for exactly IMG_W*IMG_H consecutive cycles. No gaps.
- Result: y(r,c) = sum over ch,i,j of k_ch(i,j) * x_ch(r+i-1, c+j-1).
  - Zero pad: out-of-range x = 0.
  - Replicate pad: out-of-range index clamped to [0,IMG_H-1] / [0,IMG_W-1].
- Arithmetic: full-precision signed accumulate (DW+KW+clog2(9*CH) bits), then saturate to signed OW range.
- in_valid while busy=1 and FSM != LOAD: ignored, no effect on the current frame.
- in_valid dropping early in LOAD is a protocol violation; behaviour is undefined, and recovery is by reset only.
- Back-to-back: a new frame may begin the cycle busy falls.

Optional Feature:
- Macro: CONV_MC_RELU_EN.
- Defined: opt[1]=1 (latched per frame) clamps negative post-saturation results to 0; opt[1]=0 passes the signed result.
- Undefined: opt[1] is ignored, no ReLU logic is synthesised, and the output is always the signed saturated result.

Test Plan:
- Defaults, all pixels 1, all kernels 1, opt=00 -> corners 8, edges 12, interior 18; first out_valid at T+3, 25 consecutive valids.
- Same stimulus, opt=01 -> all 25 outputs 18.
- ch0 kernel center=1 (others 0), ch1 kernel all 0, ch0 pixel = 5*r+c -> out equals 0..24 in order, for both padding modes.
- ch0 pixels -1, ch0 kernel all 1, ch1 kernel 0, opt=00 -> interior -9, corner -4. With CONV_MC_RELU_EN and opt=10 -> all outputs 0.
- OW=8 build, all pixels 127, all kernels 127, opt=01 -> all outputs 127 (saturated). Pixels -128 with kernel 127 -> all outputs -128.
- Reset pulse at the 10th out_valid cycle -> out_valid/out/busy=0 immediately (async). A following full frame produces correct results with no residue.
